// File: rtl/divider_16bit_s.sv
// Purpose: iterative 16-bit restoring divider with an optional signed mode (enabled by DIV_SIGNED_EN).
// Latency: 16 cycles from accepted start to done; a zero divisor finishes in 1 cycle.
// Backpressure: start is ignored while busy; results and flags hold until the next accepted start.
module divider_16bit_s (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] Dividend,
    input  logic [15:0] Divisor,
    input  logic        Sign_ctrl,
    output logic [15:0] Quotient,
    output logic [15:0] Remainder,
    output logic        busy,
    output logic        done,
    output logic        Div_zero,
    output logic        O
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  cnt;
    logic [15:0] rem;        // partial remainder
    logic [15:0] quo;        // dividend bits shifting out, quotient bits shifting in
    logic [15:0] dvs;        // divisor magnitude
    logic        dz;         // captured divisor was zero
    logic        neg_q;
    logic        neg_r;
    logic        ovf;

    logic        accept;
    logic [15:0] dvd_mag;
    logic [15:0] dvs_mag;
    logic        neg_q_in;
    logic        neg_r_in;
    logic        ovf_in;

    logic [16:0] shifted;
    logic [16:0] diff;
    logic        borrow;
    logic [15:0] rem_nxt;
    logic [15:0] quo_nxt;
    logic [15:0] q_fin;
    logic [15:0] r_fin;
    logic        unused_bits;

    // Start is honoured whenever no division is in flight, including the done cycle.
    assign accept = start && (state != CALC);
    assign busy   = (state == CALC);
    assign done   = (state == DONE);

`ifdef DIV_SIGNED_EN
    // Signed mode divides magnitudes; |-32768| is 16'h8000 and still fits in 16 bits.
    always_comb begin
        dvd_mag  = (Sign_ctrl && Dividend[15]) ? (16'd0 - Dividend) : Dividend;
        dvs_mag  = (Sign_ctrl && Divisor[15])  ? (16'd0 - Divisor)  : Divisor;
        neg_q_in = Sign_ctrl && (Dividend[15] ^ Divisor[15]);
        neg_r_in = Sign_ctrl && Dividend[15];
        ovf_in   = Sign_ctrl && (Dividend == 16'h8000) && (Divisor == 16'hFFFF);
    end
`else
    // Unsigned-only build: operands pass straight through and no sign fix-up happens.
    always_comb begin
        dvd_mag  = Dividend;
        dvs_mag  = Divisor;
        neg_q_in = 1'b0;
        neg_r_in = 1'b0;
        ovf_in   = 1'b0;
    end
`endif

    // One restoring step: shift in the next dividend bit, keep the difference if no borrow.
    always_comb begin
        shifted = {rem, quo[15]};
        diff    = shifted - {1'b0, dvs};
        borrow  = (shifted < {1'b0, dvs});
        rem_nxt = borrow ? shifted[15:0] : diff[15:0];
        quo_nxt = {quo[14:0], ~borrow};
        q_fin   = neg_q ? (16'd0 - quo_nxt) : quo_nxt;
        r_fin   = neg_r ? (16'd0 - rem_nxt) : rem_nxt;
    end

    // The remainder never reaches 17 bits, and Sign_ctrl is dead in the unsigned build.
    assign unused_bits = diff[16] ^ Sign_ctrl;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a zero divisor spends a single cycle in CALC, a normal run spends 16.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (dz || (cnt == 4'd15)) state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in CALC, load results on the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            rem       <= 16'd0;
            quo       <= 16'd0;
            dvs       <= 16'd0;
            dz        <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            ovf       <= 1'b0;
            Quotient  <= 16'd0;
            Remainder <= 16'd0;
            Div_zero  <= 1'b0;
            O         <= 1'b0;
        end else if (accept) begin
            cnt      <= 4'd0;
            rem      <= 16'd0;
            dz       <= (Divisor == 16'd0);
            // For a zero divisor the raw dividend is kept so it can be returned as the remainder.
            quo      <= (Divisor == 16'd0) ? Dividend : dvd_mag;
            dvs      <= dvs_mag;
            neg_q    <= neg_q_in;
            neg_r    <= neg_r_in;
            ovf      <= ovf_in;
            Div_zero <= 1'b0;
            O        <= 1'b0;
        end else if (state == CALC) begin
            if (dz) begin
                Quotient  <= 16'hFFFF;
                Remainder <= quo;
                Div_zero  <= 1'b1;
                O         <= 1'b0;
            end else begin
                rem <= rem_nxt;
                quo <= quo_nxt;
                cnt <= cnt + 4'd1;
                if (cnt == 4'd15) begin
                    Quotient  <= q_fin;
                    Remainder <= r_fin;
                    O         <= ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_divider_16bit_s.sv
// Purpose: self-checking bench for divider_16bit_s (expectations follow DIV_SIGNED_EN when defined).
// Latency: checks 16-cycle and 1-cycle done timing against a behavioural model.
// Backpressure: exercises ignored starts while busy and a restart in the done cycle.
module tb_divider_16bit_s;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] Dividend;
    logic [15:0] Divisor;
    logic        Sign_ctrl;
    logic [15:0] Quotient;
    logic [15:0] Remainder;
    logic        busy;
    logic        done;
    logic        Div_zero;
    logic        O;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        o;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_pass;
    int   n_total;

    divider_16bit_s dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Sign_ctrl (Sign_ctrl),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .busy      (busy),
        .done      (done),
        .Div_zero  (Div_zero),
        .O         (O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference using the language's own integer division (truncating).
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sc);
        exp_t e;
        int   sa;
        int   sbv;
        e.o   = 1'b0;
        e.dz  = 1'b0;
        e.lat = 16;
        if (b == 16'd0) begin
            e.q   = 16'hFFFF;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            sa  = int'(a);
            sbv = int'(b);
`ifdef DIV_SIGNED_EN
            if (sc) begin
                sa  = int'($signed(a));
                sbv = int'($signed(b));
                e.o = (a == 16'h8000) && (b == 16'hFFFF);
            end
`endif
            e.q = 16'(sa / sbv);
            e.r = 16'(sa % sbv);
        end
        return e;
    endfunction

    // Drive one start pulse, recording the expected outcome; returns 1ns after the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sc);
        Dividend  = a;
        Divisor   = b;
        Sign_ctrl = sc;
        start     = 1'b1;
        sb.push_back(model(a, b, sc));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen, bounded at 40.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 40);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        Dividend = 16'h1234;
        Divisor = 16'h0005;
        Sign_ctrl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({Quotient, Remainder, busy, done, Div_zero, O} !== 36'd0)
            $display("FAIL reset_outputs got=%h want=0", {Quotient, Remainder, busy, done, Div_zero, O});
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_idle busy/done got=%b want=00", {busy, done});
        else n_pass++;
    endtask

    task automatic test_unsigned;
        exp_t e;
        int   lat;
        issue(16'd100, 16'd7, 1'b0);
        n_total++;
        if (busy !== 1'b1) $display("FAIL unsigned_busy got=%b want=1", busy);
        else n_pass++;
        wait_done(lat);
        e = sb.pop_front();
        n_total++;
        if (lat !== 16) $display("FAIL unsigned_latency got=%0d want=16", lat);
        else n_pass++;
        n_total++;
        if ({Quotient, Remainder, Div_zero, O, busy} !== {16'd14, 16'd2, 1'b0, 1'b0, 1'b0})
            $display("FAIL unsigned_100_7 got q=%0d r=%0d dz=%b o=%b busy=%b want q=14 r=2 dz=0 o=0 busy=0",
                     Quotient, Remainder, Div_zero, O, busy);
        else n_pass++;
        n_total++;
        if ({Quotient, Remainder} !== {e.q, e.r}) $display("FAIL unsigned_model got=%h want=%h", {Quotient, Remainder}, {e.q, e.r});
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if ({done, Quotient, Remainder} !== {1'b0, 16'd14, 16'd2})
            $display("FAIL unsigned_done_pulse_hold got=%h want=%h", {done, Quotient, Remainder}, {1'b0, 16'd14, 16'd2});
        else n_pass++;
    endtask

    task automatic test_div_zero;
        exp_t e;
        int   lat;
        issue(16'hFFFF, 16'h0000, 1'b0);
        wait_done(lat);
        e = sb.pop_front();
        n_total++;
        if (lat !== 1) $display("FAIL divzero_latency got=%0d want=1", lat);
        else n_pass++;
        n_total++;
        if ({Quotient, Remainder, Div_zero, O} !== {16'hFFFF, 16'hFFFF, 1'b1, 1'b0})
            $display("FAIL divzero_result got q=%h r=%h dz=%b o=%b want q=ffff r=ffff dz=1 o=0", Quotient, Remainder, Div_zero, O);
        else n_pass++;
        n_total++;
        if ({Quotient, Remainder, Div_zero} !== {e.q, e.r, e.dz}) $display("FAIL divzero_model got=%h want=%h", {Quotient, Remainder}, {e.q, e.r});
        else n_pass++;
        // The next accepted start must clear the divide-by-zero flag.
        @(posedge clk);
        #1;
        issue(16'd20, 16'd4, 1'b0);
        n_total++;
        if (Div_zero !== 1'b0) $display("FAIL divzero_flag_clear got=%b want=0", Div_zero);
        else n_pass++;
        wait_done(lat);
        e = sb.pop_front();
        n_total++;
        if ({Quotient, Remainder, Div_zero} !== {16'd5, 16'd0, 1'b0})
            $display("FAIL divzero_followup got q=%0d r=%0d dz=%b want q=5 r=0 dz=0", Quotient, Remainder, Div_zero);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_signed;
        exp_t        e;
        int          lat;
        logic [31:0] want;
`ifdef DIV_SIGNED_EN
        want = {16'hFFFD, 16'hFFFF};
`else
        want = {16'h7FFC, 16'h0001};
`endif
        issue(16'hFFF9, 16'd2, 1'b1);
        wait_done(lat);
        e = sb.pop_front();
        n_total++;
        if (lat !== 16) $display("FAIL signed_latency got=%0d want=16", lat);
        else n_pass++;
        n_total++;
        if ({Quotient, Remainder} !== want) $display("FAIL signed_m7_2 got=%h want=%h", {Quotient, Remainder}, want);
        else n_pass++;
        n_total++;
        if ({Quotient, Remainder, O} !== {e.q, e.r, e.o}) $display("FAIL signed_model got=%h want=%h", {Quotient, Remainder, O}, {e.q, e.r, e.o});
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow;
        exp_t e;
        int   lat;
        logic want_o;
`ifdef DIV_SIGNED_EN
        want_o = 1'b1;
`else
        want_o = 1'b0;
`endif
        issue(16'h8000, 16'hFFFF, 1'b1);
        wait_done(lat);
        e = sb.pop_front();
        n_total++;
        if (O !== want_o) $display("FAIL overflow_flag got=%b want=%b", O, want_o);
        else n_pass++;
        n_total++;
        if ({Quotient, Remainder, O, Div_zero} !== {e.q, e.r, e.o, 1'b0})
            $display("FAIL overflow_result got=%h want=%h", {Quotient, Remainder, O, Div_zero}, {e.q, e.r, e.o, 1'b0});
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   lat;
        issue(16'd50, 16'd5, 1'b0);          // accepted at edge k
        repeat (4) @(posedge clk);           // now just after edge k+4
        #1;
        Dividend = 16'd9;
        Divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);                      // edge k+5: must be ignored
        #1;
        start = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL b2b_busy_during_ignored_start got=%b want=1", busy);
        else n_pass++;
        wait_done(lat);
        e = sb.pop_front();
        n_total++;
        if (lat !== 11) $display("FAIL b2b_first_latency got=%0d want=11 (after ignored start)", lat);
        else n_pass++;
        n_total++;
        if ({Quotient, Remainder} !== {16'd10, 16'd0} || {Quotient, Remainder} !== {e.q, e.r})
            $display("FAIL b2b_first_result got q=%0d r=%0d want q=10 r=0", Quotient, Remainder);
        else n_pass++;
        // Restart in the done cycle.
        issue(16'd9, 16'd3, 1'b0);
        n_total++;
        if ({done, busy} !== 2'b01) $display("FAIL b2b_restart_state got done/busy=%b want=01", {done, busy});
        else n_pass++;
        wait_done(lat);
        e = sb.pop_front();
        n_total++;
        if (lat !== 16) $display("FAIL b2b_second_latency got=%0d want=16", lat);
        else n_pass++;
        n_total++;
        if ({Quotient, Remainder} !== {16'd3, 16'd0} || {Quotient, Remainder} !== {e.q, e.r})
            $display("FAIL b2b_second_result got q=%0d r=%0d want q=3 r=0", Quotient, Remainder);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort;
        exp_t e;
        int   lat;
        int   seen_done;
        issue(16'd1000, 16'd3, 1'b0);        // accepted at edge k
        repeat (8) @(posedge clk);           // edge k+8
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({Quotient, Remainder, busy, done, Div_zero, O} !== 36'd0)
            $display("FAIL abort_outputs got=%h want=0", {Quotient, Remainder, busy, done, Div_zero, O});
        else n_pass++;
        sb.delete();
        seen_done = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
            if (rst_n == 1'b0 && seen_done == 0 && busy) seen_done = 100;
            rst_n = 1'b1;
        end
        n_total++;
        if (seen_done !== 0) $display("FAIL abort_no_done got=%0d want=0", seen_done);
        else n_pass++;
        issue(16'd1000, 16'd3, 1'b0);
        wait_done(lat);
        e = sb.pop_front();
        n_total++;
        if ({lat, Quotient, Remainder} !== {32'd16, 16'd333, 16'd1} || {Quotient, Remainder} !== {e.q, e.r})
            $display("FAIL abort_rerun got lat=%0d q=%0d r=%0d want lat=16 q=333 r=1", lat, Quotient, Remainder);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        exp_t        e;
        int          lat;
        logic [15:0] a;
        logic [15:0] b;
        logic        sc;
        for (int i = 0; i < 12; i++) begin
            a  = 16'($urandom);
            b  = (i % 4 == 3) ? 16'd0 : ((i % 2 == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom));
            if (b == 16'd0 && i % 4 != 3) b = 16'd1;
            sc = 1'($urandom_range(0, 1));
            issue(a, b, sc);
            wait_done(lat);
            e = sb.pop_front();
            n_total++;
            if ({lat, Quotient, Remainder, Div_zero, O} !== {e.lat, e.q, e.r, e.dz, e.o})
                $display("FAIL random_%0d a=%h b=%h s=%b got lat=%0d q=%h r=%h dz=%b o=%b want lat=%0d q=%h r=%h dz=%b o=%b",
                         i, a, b, sc, lat, Quotient, Remainder, Div_zero, O, e.lat, e.q, e.r, e.dz, e.o);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_unsigned();
        test_div_zero();
        test_signed();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
